// File: rtl/pulse_period_meter_pkg.sv
// Shared definitions for the pulse period meter: FSM state encoding and the
// default widths/timeout used by the meter and by users of the reference timer.
package pulse_period_meter_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2,
    TIMED_OUT  = 2'd3
  } meter_state_t;

  // Default widths, matching the reference-period timer
  localparam int DEF_REF_W       = 7;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_TIMEOUT_CYC = 255;
  localparam int DEF_STAT_W      = 8;

endpackage

// File: rtl/pulse_period_meter_sat_counter.sv
// Saturating increment counter with synchronous clear. It stops at all-ones,
// so a long run of events never wraps the statistic back to a small value.
module pulse_period_meter_sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic at_max_s;

  // Detect the saturation point
  always_comb begin
    at_max_s = 1'b0;
    if (count == {W{1'b1}}) begin
      at_max_s = 1'b1;
    end else begin
      at_max_s = 1'b0;
    end
  end

  // Count up on inc until all-ones; clear has priority
  always_ff @(posedge clock) begin
    if (clear) begin
      count <= {W{1'b0}};
    end else if (inc && !at_max_s) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/pulse_period_meter.sv
// Receive-side checker for the reference-period timer's trigger pulse.
// Measures the cycle distance between successive pulses, compares it with
// ref_value+1 and keeps saturating good/bad statistics plus a timeout flag.
// The SystemVerilog keyword "ref" cannot name a port, so the expected
// reference input is called ref_value.
module pulse_period_meter
  import pulse_period_meter_pkg::*;
#(
  parameter int REF_W       = DEF_REF_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int STAT_W      = DEF_STAT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              pulse_in,
  input  logic [REF_W-1:0]  ref_value,
  output logic [CNT_W-1:0]  period_out,
  output logic              period_valid,
  output logic              match,
  output logic              timeout,
  output logic [STAT_W-1:0] good_count,
  output logic [STAT_W-1:0] bad_count
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  meter_state_t     state_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] expected_s;
  logic             match_s;
  logic             at_timeout_s;
  logic             good_inc_s;
  logic             bad_inc_s;

  // Expected period ref_value+1; CNT_W > REF_W so the sum cannot overflow
  always_comb begin
    expected_s = CNT_W'(ref_value) + CNT_W'(1);
    match_s    = 1'b0;
    if (count_r == expected_s) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
  end

  // Counter has reached the missing-pulse threshold
  always_comb begin
    at_timeout_s = 1'b0;
    if (count_r == TIMEOUT_VAL) begin
      at_timeout_s = 1'b1;
    end else begin
      at_timeout_s = 1'b0;
    end
  end

  // Statistics events: a reported period, or a pulse-less timeout
  always_comb begin
    good_inc_s = 1'b0;
    bad_inc_s  = 1'b0;
    if (enable && (state_r == MEASURE)) begin
      if (pulse_in) begin
        good_inc_s = match_s;
        bad_inc_s  = !match_s;
      end else if (at_timeout_s) begin
        bad_inc_s = 1'b1;
      end else begin
        good_inc_s = 1'b0;
        bad_inc_s  = 1'b0;
      end
    end else begin
      good_inc_s = 1'b0;
      bad_inc_s  = 1'b0;
    end
  end

  // Measurement FSM, period counter and registered report outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      count_r      <= {CNT_W{1'b0}};
      period_out   <= {CNT_W{1'b0}};
      period_valid <= 1'b0;
      match        <= 1'b0;
      timeout      <= 1'b0;
    end else if (!enable) begin
      // Disabled: drop back to IDLE; last report and match are kept
      state_r      <= IDLE;
      count_r      <= {CNT_W{1'b0}};
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          // A pulse in the arming cycle is deliberately ignored
          state_r <= WAIT_FIRST;
          count_r <= {CNT_W{1'b0}};
        end
        WAIT_FIRST: begin
          if (pulse_in) begin
            state_r <= MEASURE;
            count_r <= CNT_W'(1);
          end else begin
            state_r <= WAIT_FIRST;
          end
        end
        MEASURE: begin
          if (pulse_in) begin
            // Pulse beats a coincident timeout and is reported normally
            period_out   <= count_r;
            period_valid <= 1'b1;
            match        <= match_s;
            count_r      <= CNT_W'(1);
          end else if (at_timeout_s) begin
            // Counter freezes at the threshold while timed out
            state_r <= TIMED_OUT;
            timeout <= 1'b1;
          end else begin
            count_r <= count_r + CNT_W'(1);
          end
        end
        TIMED_OUT: begin
          if (pulse_in) begin
            // Restart measurement; the broken interval is not reported
            state_r <= MEASURE;
            count_r <= CNT_W'(1);
            timeout <= 1'b0;
          end else begin
            state_r <= TIMED_OUT;
            timeout <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          count_r <= {CNT_W{1'b0}};
          timeout <= 1'b0;
        end
      endcase
    end
  end

  pulse_period_meter_sat_counter #(
    .W (STAT_W)
  ) u_good_count (
    .clock (clock),
    .clear (reset),
    .inc   (good_inc_s),
    .count (good_count)
  );

  pulse_period_meter_sat_counter #(
    .W (STAT_W)
  ) u_bad_count (
    .clock (clock),
    .clear (reset),
    .inc   (bad_inc_s),
    .count (bad_count)
  );

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter. A timestamp-based reference model
// predicts each reported period; a negedge monitor pops and compares.
module tb_pulse_period_meter;

  localparam int REF_W   = 7;
  localparam int CNT_W   = 8;
  localparam int TO_CYC  = 20;
  localparam int STAT_W  = 8;
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  logic              clock;
  logic              reset;
  logic              enable;
  logic              pulse_in;
  logic [REF_W-1:0]  ref_value;
  logic [CNT_W-1:0]  period_out;
  logic              period_valid;
  logic              match;
  logic              timeout;
  logic [STAT_W-1:0] good_count;
  logic [STAT_W-1:0] bad_count;

  pulse_period_meter #(
    .REF_W       (REF_W),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TO_CYC),
    .STAT_W      (STAT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .pulse_in     (pulse_in),
    .ref_value    (ref_value),
    .period_out   (period_out),
    .period_valid (period_valid),
    .match        (match),
    .timeout      (timeout),
    .good_count   (good_count),
    .bad_count    (bad_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int period;
    int m;
    int good;
    int bad;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: timestamps rather than a counter
  int cyc        = 0;
  bit armed      = 0;
  bit anchored   = 0;
  int anchor     = 0;
  int exp_to     = 0;
  int exp_good   = 0;
  int exp_bad    = 0;
  int exp_period = 0;
  int exp_match  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= STAT_MAX) ? STAT_MAX : v + 1;
  endfunction

  // Reference model: evaluated on the same sampled inputs as the DUT
  always @(posedge clock) begin
    int elapsed;
    exp_t e;
    cyc++;
    if (reset) begin
      armed = 0; anchored = 0; exp_to = 0;
      exp_good = 0; exp_bad = 0; exp_period = 0; exp_match = 0;
    end else if (!enable) begin
      armed = 0; anchored = 0; exp_to = 0;
    end else if (!armed) begin
      armed = 1;
    end else if (!anchored) begin
      if (pulse_in) begin anchored = 1; anchor = cyc; end
    end else if (exp_to != 0) begin
      if (pulse_in) begin anchor = cyc; exp_to = 0; end
    end else begin
      elapsed = cyc - anchor;
      if (pulse_in) begin
        exp_period = elapsed;
        exp_match  = (elapsed == int'(ref_value) + 1) ? 1 : 0;
        if (exp_match != 0) exp_good = sat_inc(exp_good);
        else                exp_bad  = sat_inc(exp_bad);
        e.period = exp_period; e.m = exp_match; e.good = exp_good; e.bad = exp_bad;
        exp_q.push_back(e);
        anchor = cyc;
      end else if (elapsed == TO_CYC) begin
        exp_to  = 1;
        exp_bad = sat_inc(exp_bad);
      end
    end
  end

  // Monitor: pop on every strobe, also track the level outputs each cycle
  always @(negedge clock) begin
    exp_t e;
    if (period_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sb_period", int'(period_out), e.period);
        check("sb_match",  int'(match),      e.m);
        check("sb_good",   int'(good_count), e.good);
        check("sb_bad",    int'(bad_count),  e.bad);
      end
    end else if (exp_q.size() != 0) begin
      check("missing_valid", 0, exp_q.size());
      exp_q.delete();
    end
    check("timeout",    int'(timeout),    exp_to);
    check("good_count", int'(good_count), exp_good);
    check("bad_count",  int'(bad_count),  exp_bad);
    check("period_out", int'(period_out), exp_period);
    check("match",      int'(match),      exp_match);
  end

  // Apply one cycle of inputs at the falling edge
  task automatic drive(input logic r, input logic e, input logic p, input int rv);
    @(negedge clock);
    reset     = r;
    enable    = e;
    pulse_in  = p;
    ref_value = REF_W'(rv);
  endtask

  // n pulses, each followed by gap-1 quiet cycles
  task automatic pulses(input int rv, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 1'b1, rv);
      for (int k = 0; k < gap - 1; k++) drive(1'b0, 1'b1, 1'b0, rv);
    end
  endtask

  task automatic quiet(input int rv, input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b1, 1'b0, rv);
  endtask

  task automatic do_reset(input int rv);
    drive(1'b1, 1'b0, 1'b0, rv);
    drive(1'b1, 1'b0, 1'b0, rv);
    drive(1'b0, 1'b1, 1'b0, rv);
  endtask

  initial begin
    int gap;
    int rv;
    logic rs;
    logic en;
    reset = 1'b1; enable = 1'b0; pulse_in = 1'b0; ref_value = '0;

    // Reset state
    drive(1'b1, 1'b0, 1'b0, 9);
    drive(1'b1, 1'b0, 1'b0, 9);
    check("rst_period_out", int'(period_out), 0);
    check("rst_valid",      int'(period_valid), 0);
    check("rst_match",      int'(match), 0);
    check("rst_timeout",    int'(timeout), 0);
    check("rst_good",       int'(good_count), 0);
    check("rst_bad",        int'(bad_count), 0);

    // ref=9, five pulses every 10 cycles
    drive(1'b0, 1'b1, 1'b0, 9);
    pulses(9, 5, 10);
    check("t1_period", int'(period_out), 10);
    check("t1_match",  int'(match), 1);
    check("t1_good",   int'(good_count), 4);
    check("t1_bad",    int'(bad_count), 0);

    // spacing 10,10,12
    do_reset(9);
    pulses(9, 2, 10);
    pulses(9, 1, 12);
    pulses(9, 1, 2);
    check("t2_period", int'(period_out), 12);
    check("t2_match",  int'(match), 0);
    check("t2_good",   int'(good_count), 2);
    check("t2_bad",    int'(bad_count), 1);

    // ref=0, pulse held high for 6 cycles
    do_reset(0);
    pulses(0, 6, 1);
    quiet(0, 1);
    check("t3_period", int'(period_out), 1);
    check("t3_good",   int'(good_count), 5);

    // timeout, recovery without report, then a fresh period of 10
    do_reset(9);
    pulses(9, 1, 26);
    check("t4_timeout", int'(timeout), 1);
    check("t4_bad",     int'(bad_count), 1);
    pulses(9, 1, 10);
    check("t4_cleared", int'(timeout), 0);
    pulses(9, 1, 2);
    check("t4_period", int'(period_out), 10);
    check("t4_good",   int'(good_count), 1);

    // pulse lands exactly on the timeout threshold
    do_reset(9);
    pulses(9, 1, TO_CYC);
    pulses(9, 1, 2);
    check("t5_period",  int'(period_out), TO_CYC);
    check("t5_timeout", int'(timeout), 0);

    // reset mid-measurement
    pulses(9, 1, 5);
    drive(1'b1, 1'b1, 1'b0, 9);
    drive(1'b0, 1'b1, 1'b0, 9);
    check("t6_rst_period", int'(period_out), 0);
    check("t6_rst_bad",    int'(bad_count), 0);

    // enable drop holds report and stats; re-enable needs two pulses
    quiet(9, 1);
    pulses(9, 2, 10);
    drive(1'b0, 1'b0, 1'b1, 9);
    drive(1'b0, 1'b0, 1'b0, 9);
    check("t6_hold_period", int'(period_out), 10);
    check("t6_hold_good",   int'(good_count), 1);
    drive(1'b0, 1'b1, 1'b1, 9);
    pulses(9, 2, 10);
    check("t6_reen_good", int'(good_count), 2);

    // bad_count saturation
    do_reset(5);
    pulses(5, 305, 1);
    quiet(5, 1);
    check("t7_bad_sat", int'(bad_count), STAT_MAX);
    check("t7_good",    int'(good_count), 0);

    // randomized traffic
    do_reset(9);
    for (int n = 0; n < 200; n++) begin
      gap = ($urandom_range(0, 1) == 0) ? 10 : int'($urandom_range(1, 26));
      rv  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : 9;
      rs  = ($urandom_range(0, 40) == 0);
      en  = ($urandom_range(0, 15) != 0);
      for (int k = 0; k < gap - 1; k++) drive(1'b0, en, 1'b0, rv);
      drive(rs, en, 1'b1, rv);
    end
    quiet(9, 3);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Receive-side checker for the periodic one-cycle trigger pulse produced by the team's reference-period timer.
- Measures the clock-cycle interval between successive pulses and compares it with the expected period, ref+1.
- Reports each period with a valid strobe, a match flag, saturating good/bad counters, and a timeout if pulses stop.
- Sits beside the timer in the same clock domain, for self-check and debug.

Parameters:
- REF_W, 7, width of the ref input (same as the timer's reference width).
- CNT_W, 8, width of the period counter and period_out; must be at least REF_W+1.
- TIMEOUT_CYC, 255, counter value at which a missing pulse is declared; must fit in CNT_W and be at least 2.
- STAT_W, 8, width of the saturating statistics counters.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = measure; 0 = return to IDLE.
- pulse_in  input  1  trigger pulse; every sampled-high cycle counts as one pulse.
- ref  input  REF_W  expected reference; expected period = ref+1 cycles.
- period_out  output  CNT_W  last measured period in cycles.
- period_valid  output  1  one-cycle strobe when period_out/match update.
- match  output  1  last period equalled ref+1.
- timeout  output  1  no pulse for TIMEOUT_CYC cycles; level.
- good_count  output  STAT_W  matching periods, saturating.
- bad_count  output  STAT_W  mismatching periods plus timeouts, saturating.

Behaviour:
- Reset: synchronous and active-high; one clock domain.
  - State IDLE; counter 0.
  - period_out 0, period_valid 0, match 0, timeout 0, good_count 0, bad_count 0.
  - Reset overrides every other input, including mid-measurement.
- All outputs are registered.
- States: IDLE, WAIT_FIRST, MEASURE, TIMED_OUT.
- enable=0 in any state:
  - Next state IDLE; counter 0; period_valid 0; timeout 0.
  - period_out, match and the statistics counters hold.
- IDLE with enable=1: go to WAIT_FIRST. A pulse sampled in this same cycle is ignored.
- WAIT_FIRST with pulse_in=1: go to MEASURE; counter <= 1; no period_valid.
- MEASURE with no pulse: counter <= counter+1.
- MEASURE with pulse_in=1:
  - period_out <= counter; period_valid <= 1 for one cycle; counter <= 1.
  - match <= (counter == zero-extended ref + 1), computed in CNT_W bits; no overflow because CNT_W > REF_W.
  - good_count or bad_count increments, saturating at all-ones.
- Period definition: pulses sampled at edges t and t+P give period_out = P. Consecutive high cycles give P = 1.
- MEASURE with no pulse and counter == TIMEOUT_CYC:
  - Go to TIMED_OUT; timeout <= 1; bad_count increments (saturating); counter holds.
- Pulse and timeout condition in the same cycle: the pulse wins and is handled as a normal MEASURE pulse; no timeout.
- TIMED_OUT with pulse_in=1:
  - Go to MEASURE; counter <= 1; timeout <= 0.
  - No period_valid; the interrupted interval is not reported.
- TIMED_OUT with no pulse: hold; timeout stays 1.
- ref changing mid-measurement: the comparison uses ref as sampled on the pulse cycle.
- period_valid is 0 in every cycle without a reported period.
- Counter saturation: TIMEOUT_CYC bounds the counter, so it never wraps.

Decomposition:
- Shared package:
  - State enum: IDLE, WAIT_FIRST, MEASURE, TIMED_OUT.
  - Default widths REF_W/CNT_W/STAT_W and the TIMEOUT_CYC default, reused by the timer's users.
- One natural sub-module: sat_counter, a saturating, parameterised-width increment counter with synchronous clear. It is instantiated twice, for good_count and bad_count.
- The FSM and period counter stay in the top.

Test Plan:
- Drive the timer model with ref=9, enable=1 for 5 pulses → first period_valid at the 2nd pulse; period_out=10, match=1; good_count=4, bad_count=0.
- ref=9, pulses spaced 10,10,12 cycles → period_out sequence 10,10,12; match 1,1,0; good_count=2, bad_count=1.
- ref=0, pulse_in held high 6 cycles → period_out=1, match=1 each cycle after the first pulse; good_count=5.
- TIMEOUT_CYC=20, one pulse then silence → timeout=1 exactly 20 cycles after the pulse edge, bad_count=1. Next pulse clears timeout with no period_valid. The following pulse 10 cycles later gives period_out=10.
- Pulse coinciding with counter==TIMEOUT_CYC → period_valid=1, period_out=TIMEOUT_CYC, timeout stays 0.
- Reset asserted mid-MEASURE with counter=5, and separately enable dropped → reset clears all outputs to 0 on the next edge. enable=0 gives IDLE with period_out/counts held. Re-enabling needs two pulses before the next period_valid.
- Counter saturation: force 300 mismatches with STAT_W=8 → bad_count stays at 255.
